// File: rtl/q24mul16_pkg.sv
// Shared DSP constants for the Q8.16 x integer rounding multiplier.
// Holds the widths, the fraction/iteration counts and the FSM state encoding.
package q24mul16_pkg;

  localparam int Q_QW      = 24;
  localparam int Q_BW      = 16;
  localparam int FRAC_BITS = 16;
  localparam int ITERS     = 16;
  localparam int Q_ACC_W   = Q_QW + Q_BW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/q24mul16_if.sv
// Operand/result bundle for q24mul16: the requester drives the master side,
// the multiplier sits on the slave side.
interface q24mul16_if #(
  parameter int QW = 24,
  parameter int BW = 16
);

  logic [QW-1:0] qin;
  logic [BW-1:0] bin;
  logic          iv;
  logic [QW-1:0] pout;
  logic          ov;
  logic          busy;

  modport master (output qin, bin, iv, input pout, ov, busy);
  modport slave  (input qin, bin, iv, output pout, ov, busy);

endinterface

// File: rtl/q24mul16.sv
// Sequential shift-add multiplier: pout = round_half_up(qin*bin / 2^16).
// One multiplier bit per cycle, 17 cycles from capture to ov.
module q24mul16
  import q24mul16_pkg::*;
#(
  parameter int QW = Q_QW,
  parameter int BW = Q_BW
) (
  input  logic        clk,
  input  logic        rst,
  q24mul16_if.slave   bus
);

  localparam int ACC_W = QW + BW;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  // Seeding the accumulator with half an LSB makes the final slice round half up.
  localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(1) << (FRAC_BITS - 1);

  state_e           state_q,  state_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [ACC_W-1:0] mcand_q,  mcand_d;
  logic [BW-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [QW-1:0]    pout_q,   pout_d;
  logic             ov_q,     ov_d;
  logic             busy_q,   busy_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    ov_d     = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iv) begin
          mcand_d  = ACC_W'(bus.qin);
          mplier_d = bus.bin;
          acc_d    = ACC_INIT;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Multiplicand walks left while the multiplier drains LSB first.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        pout_d  = acc_q[FRAC_BITS +: QW];
        ov_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      pout_q   <= pout_d;
      ov_q     <= ov_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pout = pout_q;
  assign bus.ov   = ov_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_q24mul16.sv
// Bench for q24mul16: directed vector table, hand-built corner sequences and
// a randomized regression against a plain-arithmetic rounding model.
module tb_q24mul16;

  localparam int QW = 24;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q24mul16_if #(.QW(QW), .BW(BW)) bus ();
  q24mul16 #(.QW(QW), .BW(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [QW-1:0] q;
    logic [BW-1:0] b;
    logic [QW-1:0] e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [QW-1:0] last_pout;

  function automatic logic [QW-1:0] ref_mul(logic [QW-1:0] q, logic [BW-1:0] b);
    longint unsigned p;
    p = q;
    p = p * b + 64'd32768;
    return QW'(p >> 16);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (iv sampled at the next edge), scramble inputs while busy,
  // then check latency, result, busy release and pout hold.
  task automatic run_op(logic [QW-1:0] q, logic [BW-1:0] b, logic [QW-1:0] e, string name);
    int  lat;
    bit  hold_bad;
    bus.qin = q;
    bus.bin = b;
    bus.iv  = 1'b1;
    tick();
    check({name, ".ov_drop"}, bus.ov, 1'b0);
    check({name, ".busy"}, bus.busy, 1'b1);
    lat = 0;
    hold_bad = 1'b0;
    while (!bus.ov && lat < 40) begin
      bus.qin = QW'($urandom);
      bus.bin = BW'($urandom);
      bus.iv  = 1'($urandom);
      tick();
      lat++;
      if (!bus.ov && bus.pout !== last_pout) hold_bad = 1'b1;
    end
    bus.iv = 1'b0;
    check({name, ".lat"}, lat, 17);
    check({name, ".pout"}, bus.pout, e);
    check({name, ".busy_rel"}, bus.busy, 1'b0);
    check({name, ".hold"}, hold_bad, 1'b0);
    last_pout = bus.pout;
  endtask

  initial begin
    vec_t tbl[8];
    int   n_ov;
    int   first_lat;
    logic [QW-1:0] cap_pout;
    logic [QW-1:0] rq;
    logic [BW-1:0] rb;

    tbl[0] = '{24'h010000, 16'hB504, 24'h00B504};
    tbl[1] = '{24'h018000, 16'h0003, 24'h000005};
    tbl[2] = '{24'h014000, 16'h0001, 24'h000001};
    tbl[3] = '{24'hFFFFFF, 16'hFFFF, 24'hFFFEFF};
    tbl[4] = '{24'h000000, 16'hFFFF, 24'h000000};
    tbl[5] = '{24'hFFFFFF, 16'h0000, 24'h000000};
    tbl[6] = '{24'h008000, 16'h0001, 24'h000001};
    tbl[7] = '{24'h00FFFF, 16'h0001, 24'h000001};

    rst = 1'b1;
    bus.iv = 1'b0;
    bus.qin = '0;
    bus.bin = '0;
    repeat (2) tick();
    check("rst.pout", bus.pout, 0);
    check("rst.ov", bus.ov, 0);
    check("rst.busy", bus.busy, 0);
    rst = 1'b0;
    last_pout = '0;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].q, tbl[i].b, tbl[i].e, $sformatf("vec%0d", i));

    // Second iv five cycles into the op must be ignored.
    tick();
    bus.qin = 24'h020000;
    bus.bin = 16'h0010;
    bus.iv  = 1'b1;
    tick();
    bus.iv = 1'b0;
    repeat (4) tick();
    bus.qin = 24'h123456;
    bus.bin = 16'hFFFF;
    bus.iv  = 1'b1;
    tick();
    bus.iv = 1'b0;
    n_ov = 0;
    first_lat = 0;
    cap_pout = '0;
    for (int k = 6; k <= 45; k++) begin
      tick();
      if (bus.ov) begin
        n_ov++;
        if (first_lat == 0) begin
          first_lat = k;
          cap_pout = bus.pout;
        end
      end
    end
    check("busy_iv.n_ov", n_ov, 1);
    check("busy_iv.lat", first_lat, 17);
    check("busy_iv.pout", cap_pout, 24'h000020);
    last_pout = bus.pout;

    // Reset at cycle 8 of RUN aborts the op; the next op runs normally.
    bus.qin = 24'h030000;
    bus.bin = 16'h0101;
    bus.iv  = 1'b1;
    tick();
    bus.iv = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", bus.busy, 0);
    check("abort.pout", bus.pout, 0);
    check("abort.ov", bus.ov, 0);
    last_pout = '0;
    run_op(24'h030000, 16'h0101, 24'h000303, "abort.next");

    // rst and iv at the same edge: iv must be dropped.
    bus.qin = 24'h010000;
    bus.bin = 16'h0005;
    bus.iv  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.iv = 1'b0;
    last_pout = '0;
    tick();
    check("rst_iv.busy", bus.busy, 0);
    n_ov = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.ov) n_ov++;
    end
    check("rst_iv.no_ov", n_ov, 0);

    // Back-to-back random ops at the minimum 18-cycle issue period.
    for (int i = 0; i < 1000; i++) begin
      rq = QW'($urandom);
      rb = BW'($urandom);
      if (i % 50 == 0) rq = '1;
      if (i % 50 == 1) rb = '1;
      run_op(rq, rb, ref_mul(rq, rb), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q24mul16.md
Q24MUL16 -- requirements
Module: q24mul16

Interface
REQ-001 The block SHALL have parameter QW, default 24, meaning the multiplicand (quotient) width.
REQ-002 The block SHALL have parameter BW, default 16, meaning the multiplier width and the number of fraction bits in qin.
REQ-003 clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 qin  input  QW  is the unsigned Q8.16 quotient, as produced by the divider's qout.
REQ-006 bin  input  BW  is the unsigned integer multiplier, i.e. the divisor to be reapplied.
REQ-007 iv  input  1  is the input-valid strobe; qin and bin are captured on an edge where iv=1 and busy=0.
REQ-008 pout  output  QW  is the rounded integer product, round(qin*bin / 2^16).
REQ-009 ov  output  1  is the output-valid pulse, high for exactly one cycle when pout is updated.
REQ-010 busy  output  1  is high while an operation is in progress; iv is ignored while busy=1.

Function
REQ-011 The block SHALL compute pout = floor((qin*bin + 2^15) / 2^16) exactly (round half up), with no truncation error.
REQ-012 The block SHALL keep a 40-bit internal accumulator; the result provably fits in 24 bits, so no saturation logic is required.
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 IDLE: on iv=1 the block SHALL capture qin and bin, initialise the accumulator to 0x8000, clear the bit counter, set busy=1 and go to RUN.
REQ-015 RUN: on each cycle the block SHALL process one multiplier bit, LSB first (accumulator += qin_r<<i when bin_r[i]=1), for exactly 16 cycles, then go to DONE.
REQ-016 DONE: the block SHALL load pout from accumulator[39:16], pulse ov=1 for one cycle, set busy=0 and return to IDLE.
REQ-017 Latency: for iv sampled at edge E0, pout and ov SHALL become valid after edge E17; ov SHALL drop after E18.
REQ-018 Throughput: iv SHALL be accepted at the earliest at edge E18, giving a minimum issue period of 18 cycles.
REQ-019 iv asserted while busy=1 SHALL be ignored entirely; the captured operands and the in-flight result SHALL be unchanged.
REQ-020 pout SHALL hold its last value until the next DONE, independent of iv, qin and bin.
REQ-021 Captured operands SHALL be registered, so changes on qin and bin after E0 SHALL NOT affect the result.
REQ-022 bin=0 or qin=0 SHALL still take the full 17-cycle latency and SHALL yield pout=0.

Reset
REQ-023 With rst=1 at an edge, the block SHALL enter IDLE with pout=0, ov=0, busy=0, accumulator=0 and counter=0.
REQ-024 Reset in RUN or DONE SHALL abort the operation, and no ov pulse SHALL be produced for it.
REQ-025 rst SHALL take priority over iv at the same edge; that iv SHALL be dropped.

Structure
REQ-026 QW, BW, the fraction-bit count (16), the iteration count (16) and the state encoding SHALL live in the shared DSP constants package.
REQ-027 The block SHALL be a single module with no sub-modules; the shift-add datapath and the FSM SHALL be coded inline.

Verification
REQ-028 qin=0x010000, bin=0xB504 -> pout=0x00B504, with ov exactly 17 cycles after iv.
REQ-029 qin=0x018000, bin=0x0003 -> pout=0x000005 (4.5 rounds up); qin=0x014000, bin=0x0001 -> pout=0x000001 (1.25 rounds down).
REQ-030 qin=0xFFFFFF, bin=0xFFFF -> pout=0xFFFEFF, with no overflow.
REQ-031 Issue iv with qin=0x020000, bin=0x0010, then a second iv 5 cycles later with different operands -> exactly one ov, pout=0x000020, and the second request ignored.
REQ-032 Assert rst for one cycle at cycle 8 of RUN -> no ov, pout=0, busy=0; a new iv on the next cycle completes normally after 17 cycles.
REQ-033 Run a random regression of 1000 operand pairs issued every 18 cycles against the formula in REQ-011 -> zero mismatches.
